mem_wait_responder: RTL and testbench

Memory-side responder for the multicycle CPU's data/instruction port. It holds word storage and serves one read or write per request over a req/ready handshake, with a configurable number of wait states. This lets the control unit run against slower memory models instead of the fixed one-cycle memory. It sits between the CPU address mux/store-size path and the instruction/memory-data registers.

---
 rtl/mem_wait_responder.sv | 162 ++++++++++++++++
 tb/tb_mem_wait_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wait_responder.sv
// Word-addressed storage served over a req/ready handshake. A fixed number of
// wait states separates request acceptance from the single-cycle response.
module mem_wait_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [31:0] i_address,
  input  logic [31:0] i_data_in,
  output logic [31:0] o_data_out,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_error
);
  // state | meaning
  // IDLE  | waiting for req; a sampled req captures wr/address/data_in
  // WAIT  | counting down wait states; req ignored
  // RESP  | storage accessed on entry; ready (and error) high this cycle
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_L  = 4'(WAIT_STATES);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_count;
  logic        r_wr;
  logic [29:0] r_index;
  logic [31:0] r_data;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0] r_data_out;
  logic        r_ready;
  logic        r_busy;
  logic        r_error;

  logic        w_acc_wr;
  logic [29:0] w_acc_index;
  logic [31:0] w_acc_data;
  logic        w_in_range;
  logic        w_access;
  logic        w_mem_we;
  logic        w_rd_load;
  logic        w_ready_nxt;
  logic        w_busy_nxt;
  logic        w_error_nxt;
  logic        w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^i_address[1:0];

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_next = (WAIT_L == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_count <= 4'd1) begin
          w_next = S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the acceptance edge itself,
  // before the capture registers hold the request, so take the live inputs.
  always_comb begin
    w_acc_wr    = r_wr;
    w_acc_index = r_index;
    w_acc_data  = r_data;
    if (r_state == S_IDLE) begin
      w_acc_wr    = i_wr;
      w_acc_index = i_address[31:2];
      w_acc_data  = i_data_in;
    end
    w_in_range  = ({2'b00, w_acc_index} < DEPTH_L);
    w_access    = (w_next == S_RESP) && (r_state != S_RESP);
    w_mem_we    = w_access && w_acc_wr && w_in_range;
    w_rd_load   = w_access && !w_acc_wr;
    w_ready_nxt = (w_next == S_RESP);
    w_busy_nxt  = (w_next != S_IDLE);
    w_error_nxt = w_access && !w_in_range;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= 4'd0;
      r_wr    <= 1'b0;
      r_index <= 30'd0;
      r_data  <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_count <= WAIT_L;
            r_wr    <= i_wr;
            r_index <= i_address[31:2];
            r_data  <= i_data_in;
          end
        end
        S_WAIT: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end
        end
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset; a reset on the access edge still blocks the write.
  always_ff @(posedge i_clock) begin
    if (!i_reset && w_mem_we) begin
      r_mem[w_acc_index[IDX_W-1:0]] <= w_acc_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_data_out <= 32'd0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_error <= w_error_nxt;
      if (w_rd_load) begin
        r_data_out <= w_in_range ? r_mem[w_acc_index[IDX_W-1:0]] : 32'd0;
      end
    end
  end

  assign o_data_out = r_data_out;
  assign o_ready    = r_ready;
  assign o_busy     = r_busy;
  assign o_error    = r_error;

endmodule

// File: tb/tb_mem_wait_responder.sv
// Bench for mem_wait_responder: three instances (2, 0 and 3 wait states)
// driven from a vector table plus hand sequences for timing corner cases.
module tb_mem_wait_responder;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [NI];
  logic        req  [NI];
  logic        wr   [NI];
  logic [31:0] addr [NI];
  logic [31:0] din  [NI];
  logic [31:0] dout [NI];
  logic        rdy  [NI];
  logic        bsy  [NI];
  logic        err  [NI];

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      mem_wait_responder #(
        .DEPTH_WORDS(64),
        .WAIT_STATES((g == 0) ? 2 : ((g == 1) ? 0 : 3))
      ) u_dut (
        .i_clock   (clk),
        .i_reset   (rst[g]),
        .i_req     (req[g]),
        .i_wr      (wr[g]),
        .i_address (addr[g]),
        .i_data_in (din[g]),
        .o_data_out(dout[g]),
        .o_ready   (rdy[g]),
        .o_busy    (bsy[g]),
        .o_error   (err[g])
      );
    end
  endgenerate

  typedef struct {
    int          inst;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] ed;
    logic        ee;
    string       nm;
  } vec_t;

  typedef struct {
    logic [31:0] ed;
    logic        ee;
    logic        w;
    int          inst;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] last_rd [NI];
  int          n_checks = 0;
  int          n_err    = 0;

  function automatic int ws_of(input int n);
    return (n == 0) ? 2 : ((n == 1) ? 0 : 3);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  task automatic do_txn(input int n, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] ed,
                        input logic ee, input string nm);
    exp_t e;
    int   lat;
    bit   got;
    req[n]  = 1'b1;
    wr[n]   = w;
    addr[n] = a;
    din[n]  = d;
    e.ed = ed; e.ee = ee; e.w = w; e.inst = n;
    sbq.push_back(e);
    got = 1'b0;
    lat = 0;
    while (!got && lat < 40) begin
      step();
      lat++;
      req[n]  = 1'b0;
      wr[n]   = ~w;
      addr[n] = $urandom;
      din[n]  = $urandom;
      if (rdy[n]) begin
        got = 1'b1;
        e = sbq.pop_front();
        chk({nm, " latency"}, 32'(lat), 32'(ws_of(n) + 1));
        chk({nm, " busy@ready"}, 32'(bsy[n]), 32'd1);
        chk({nm, " error"}, 32'(err[n]), 32'(e.ee));
        if (!e.w) last_rd[n] = e.ed;
        chk({nm, " data_out"}, dout[n], last_rd[n]);
      end else begin
        chk({nm, " busy"}, 32'(bsy[n]), 32'd1);
      end
    end
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL %s timeout: no ready within 40 cycles", nm);
      if (sbq.size() > 0) e = sbq.pop_front();
    end
    step();
    chk({nm, " ready after"}, 32'(rdy[n]), 32'd0);
    chk({nm, " busy after"}, 32'(bsy[n]), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [16];
    vt[0]  = '{0, 1'b1, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0, "wr_10"};
    vt[1]  = '{0, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, "rd_10"};
    vt[2]  = '{0, 1'b1, 32'h23,       32'h12345678, 32'h0,        1'b0, "wr_23"};
    vt[3]  = '{0, 1'b0, 32'h20,       32'h0,        32'h12345678, 1'b0, "rd_20"};
    vt[4]  = '{0, 1'b1, 32'hFC,       32'hA5A50001, 32'h0,        1'b0, "wr_fc"};
    vt[5]  = '{0, 1'b1, 32'h100,      32'hFFFFFFFF, 32'h0,        1'b1, "wr_oor"};
    vt[6]  = '{0, 1'b0, 32'hFC,       32'h0,        32'hA5A50001, 1'b0, "rd_fc"};
    vt[7]  = '{0, 1'b0, 32'h100,      32'h0,        32'h0,        1'b1, "rd_oor"};
    vt[8]  = '{0, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1, "rd_top"};
    vt[9]  = '{0, 1'b1, 32'h30,       32'h30303030, 32'h0,        1'b0, "wr_30"};
    vt[10] = '{0, 1'b1, 32'h34,       32'h34343434, 32'h0,        1'b0, "wr_34"};
    vt[11] = '{0, 1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, "rd_10b"};
    vt[12] = '{1, 1'b1, 32'h00,       32'h00000227, 32'h0,        1'b0, "z_wr_00"};
    vt[13] = '{1, 1'b0, 32'h00,       32'h0,        32'h00000227, 1'b0, "z_rd_00"};
    vt[14] = '{2, 1'b1, 32'h08,       32'h0BAD0008, 32'h0,        1'b0, "w3_wr_08"};
    vt[15] = '{2, 1'b0, 32'h08,       32'h0,        32'h0BAD0008, 1'b0, "w3_rd_08"};

    for (int n = 0; n < NI; n++) begin
      rst[n] = 1'b1; req[n] = 1'b0; wr[n] = 1'b0;
      addr[n] = 32'h0; din[n] = 32'h0; last_rd[n] = 32'h0;
    end
    step();
    step();
    // reset and req in the same cycle: reset wins
    req[0] = 1'b1; addr[0] = 32'h10;
    step();
    for (int n = 0; n < NI; n++) rst[n] = 1'b0;
    req[0] = 1'b0;
    for (int n = 0; n < NI; n++) begin
      chk("reset ready", 32'(rdy[n]), 32'd0);
      chk("reset busy", 32'(bsy[n]), 32'd0);
      chk("reset error", 32'(err[n]), 32'd0);
      chk("reset data_out", dout[n], 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst+req ready", 32'(rdy[0]), 32'd0);
      chk("rst+req busy", 32'(bsy[0]), 32'd0);
    end

    for (int i = 0; i < 16; i++) begin
      do_txn(vt[i].inst, vt[i].w, vt[i].a, vt[i].d, vt[i].ed, vt[i].ee, vt[i].nm);
    end

    // held req, zero wait states: accepted every 2 cycles
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h0;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("z_held ready", 32'(rdy[1]), 32'(i % 2));
      if (rdy[1]) chk("z_held data", dout[1], 32'h00000227);
      if (i == 6) req[1] = 1'b0;
    end
    step();
    chk("z_held idle", 32'(rdy[1]), 32'd0);

    // held req, two wait states: accepted every 4 cycles
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h10;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("w2_held ready", 32'(rdy[0]), 32'((i % 4) == 3));
      chk("w2_held busy", 32'(bsy[0]), 32'((i % 4) != 0));
      if (rdy[0]) chk("w2_held data", dout[0], 32'hDEADBEEF);
      if (i == 8) req[0] = 1'b0;
    end
    last_rd[0] = 32'hDEADBEEF;
    step();
    chk("w2_held idle busy", 32'(bsy[0]), 32'd0);

    // request during WAIT is ignored
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h30; din[0] = 32'h33333333;
    step();
    addr[0] = 32'h34; din[0] = 32'h44444444;
    step();
    req[0] = 1'b0;
    chk("busyreq no early ready", 32'(rdy[0]), 32'd0);
    step();
    chk("busyreq ready", 32'(rdy[0]), 32'd1);
    chk("busyreq error", 32'(err[0]), 32'd0);
    chk("busyreq data_out held", dout[0], last_rd[0]);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("busyreq no second ready", 32'(rdy[0]), 32'd0);
    end
    do_txn(0, 1'b0, 32'h34, 32'h0, 32'h34343434, 1'b0, "busyreq rd_34");
    do_txn(0, 1'b0, 32'h30, 32'h0, 32'h33333333, 1'b0, "busyreq rd_30");

    // reset in the second WAIT cycle aborts a write
    req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h08; din[2] = 32'hCAFEF00D;
    step();
    req[2] = 1'b0;
    chk("abort busy", 32'(bsy[2]), 32'd1);
    step();
    rst[2] = 1'b1;
    step();
    rst[2] = 1'b0;
    last_rd[2] = 32'h0;
    chk("abort ready", 32'(rdy[2]), 32'd0);
    chk("abort busy cleared", 32'(bsy[2]), 32'd0);
    chk("abort error", 32'(err[2]), 32'd0);
    chk("abort data_out", dout[2], 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort no ready", 32'(rdy[2]), 32'd0);
    end
    do_txn(2, 1'b0, 32'h08, 32'h0, 32'h0BAD0008, 1'b0, "abort rd_08");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
